limber_lhb_arbctl: RTL

LIMBER_LHB_ARBCTL -- requirements
Module: limber_lhb_arbctl

---
 rtl/limber_lhb_pkg.sv | 20 ++
 rtl/limber_gnrl_rr_pick.sv | 28 ++
 rtl/limber_lhb_arbctl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/limber_lhb_pkg.sv
// Shared types and constants for the LHB arbiter/controller.
package limber_lhb_pkg;

    // Arbiter controller FSM encoding.
    typedef enum logic [1:0] {
        LHB_IDLE = 2'd0,
        LHB_REQ  = 2'd1,
        LHB_RSP  = 2'd2
    } lhb_state_e;

    // Read data returned alongside a timeout error.
    localparam int LHB_ERR_RDATA = 0;

    // Width of the response-wait counter; kept at least 1 bit so the
    // register still exists when the timeout is disabled.
    function automatic int lhb_cnt_width(input int tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/limber_gnrl_rr_pick.sv
// Stateless round-robin picker: grants the first requester strictly
// above last_i, wrapping modulo N. Output is one-hot, or zero if idle.
module limber_gnrl_rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  grant_o
);

    // Scan N slots starting just above the last-served index.
    always_comb begin
        int   idx;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_i) + i) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/limber_lhb_arbctl.sv
// N-master to single-target LHB arbiter/controller. One transaction in
// flight at a time: grant (IDLE), forward request (REQ), wait for the
// target response or timeout (RSP), then return the response to the owner.
//
// Handshake: a request transfers on any cycle where valid and ready are
// both high; valid may be withdrawn before that, which abandons the
// request. Responses carry no ready and are a single-cycle strobe.
module limber_lhb_arbctl
    import limber_lhb_pkg::*;
#(
    parameter int N   = 4,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_m_req_valid,
    output logic [N-1:0]    o_m_req_ready,
    input  logic [N*AW-1:0] i_m_req_addr,
    input  logic [N*DW-1:0] i_m_req_wdata,
    input  logic [N-1:0]    i_m_req_we,
    output logic [N-1:0]    o_m_rsp_valid,
    output logic [DW-1:0]   o_m_rsp_rdata,
    output logic            o_m_rsp_err,
    output logic            o_s_req_valid,
    input  logic            i_s_req_ready,
    output logic [AW-1:0]   o_s_req_addr,
    output logic [DW-1:0]   o_s_req_wdata,
    output logic            o_s_req_we,
    input  logic            i_s_rsp_valid,
    input  logic [DW-1:0]   i_s_rsp_rdata,
    input  logic            i_s_rsp_err,
    output logic            o_busy
);

    localparam int             LW       = $clog2(N);
    localparam int             CW       = lhb_cnt_width(TMO);
    localparam logic [LW-1:0]  LAST_RST = LW'(N - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);

    lhb_state_e     state_q, state_d;
    logic [N-1:0]   owner_q, owner_d;
    logic [LW-1:0]  last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [N-1:0]   grant;
    logic [LW-1:0]  owner_idx;

    limber_gnrl_rr_pick #(
        .N  (N),
        .LW (LW)
    ) u_rr_pick (
        .req_i   (i_m_req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Binary index of the one-hot owner, used to mux the owner's fields.
    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q[k]) owner_idx = LW'(k);
        end
    end

    // Next-state logic plus the combinational target-side outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        o_s_req_valid = 1'b0;
        o_s_req_addr  = '0;
        o_s_req_wdata = '0;
        o_s_req_we    = 1'b0;
        o_m_req_ready = '0;
        case (state_q)
            LHB_IDLE: begin
                if (|i_m_req_valid) begin
                    owner_d = grant;
                    state_d = LHB_REQ;
                end
            end
            LHB_REQ: begin
                o_s_req_valid = i_m_req_valid[owner_idx];
                o_s_req_addr  = i_m_req_addr[owner_idx*AW +: AW];
                o_s_req_wdata = i_m_req_wdata[owner_idx*DW +: DW];
                o_s_req_we    = i_m_req_we[owner_idx];
                o_m_req_ready = owner_q & {N{i_s_req_ready}};
                if (!i_m_req_valid[owner_idx]) begin
                    // Owner withdrew: drop it without touching fairness state.
                    state_d = LHB_IDLE;
                end else if (i_s_req_ready) begin
                    state_d = LHB_RSP;
                    cnt_d   = '0;
                end
            end
            LHB_RSP: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (i_s_rsp_valid) begin
                    // A real response beats a timeout in the same cycle.
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = i_s_rsp_rdata;
                    rsp_err_d   = i_s_rsp_err;
                    last_d      = owner_idx;
                    state_d     = LHB_IDLE;
                end else if ((TMO > 0) && (cnt_q == TMO_LAST)) begin
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = DW'(LHB_ERR_RDATA);
                    rsp_err_d   = 1'b1;
                    last_d      = owner_idx;
                    state_d     = LHB_IDLE;
                end
            end
            default: state_d = LHB_IDLE;
        endcase
    end

    // State and registered response path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= LHB_IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_m_rsp_valid = rsp_valid_q;
    assign o_m_rsp_rdata = rsp_rdata_q;
    assign o_m_rsp_err   = rsp_err_q;
    assign o_busy        = (state_q != LHB_IDLE);

endmodule
